// File: rtl/trig_pkg.sv
// Shared definitions for the trigger sequencer: FSM encoding, level-write
// select codes and default parameter values.
package trig_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_RST     = 3'd3,
        S_ARM     = 3'd4,
        S_WAIT_T1 = 3'd5,
        S_FINISH  = 3'd6
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;

    localparam int TS_WIDTH_DEF   = 32;
    localparam int RST_CYCLES_DEF = 4;

endpackage

// File: rtl/edge_det.sv
// Registered rise/fall detector: each pulse appears one cycle after the
// input transition is sampled.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic prev_q, rise_q, fall_q;
    logic prev_d, rise_d, fall_d;

    // compare the current sample against the previous one
    always_comb begin
        prev_d = din;
        rise_d = din & ~prev_q;
        fall_d = ~din & prev_q;
    end

    // edge history and pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/trig_seq_ctrl.sv
// Trigger sequencer: programs two levels, pulses the trigger-generator
// reset, then timestamps a channel-A fall and a following channel-B rise.
module trig_seq_ctrl
    import trig_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                adc_clk,
    input  logic                adc_rst_n,
    input  logic                cmd_start,
    input  logic                cmd_abort,
    input  logic [15:0]         cfg_level_a,
    input  logic [15:0]         cfg_level_b,
    input  logic [TS_WIDTH-1:0] cfg_timeout,
    input  logic                trigger0,
    input  logic                trigger1,
    output logic                trig_reset,
    output logic [1:0]          trig_level_add,
    output logic [15:0]         trig_level,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [TS_WIDTH-1:0] ts_t0,
    output logic [TS_WIDTH-1:0] ts_t1
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]     RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [TS_WIDTH-1:0] TS_ONES = {TS_WIDTH{1'b1}};
    localparam logic [TS_WIDTH-1:0] TS_ZERO = {TS_WIDTH{1'b0}};

    state_e              state_q, state_d;
    logic [15:0]         lvl_b_q, lvl_b_d;
    logic [TS_WIDTH-1:0] to_q, to_d;
    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0] ts_t0_q, ts_t0_d;
    logic [TS_WIDTH-1:0] ts_t1_q, ts_t1_d;
    logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic                seen_high_q, seen_high_d;
    logic                trig_reset_q, trig_reset_d;
    logic [1:0]          add_q, add_d;
    logic [15:0]         level_q, level_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    logic rise0_s, fall0_s, rise1_s, fall1_s;
    logic to_hit_s;
    logic unused_s;

    edge_det u_edge0 (.clk(adc_clk), .rst_n(adc_rst_n), .din(trigger0), .rise(rise0_s), .fall(fall0_s));
    edge_det u_edge1 (.clk(adc_clk), .rst_n(adc_rst_n), .din(trigger1), .rise(rise1_s), .fall(fall1_s));

    assign unused_s = rise0_s | fall1_s;
    assign to_hit_s = (to_q != TS_ZERO) && (ts_cnt_q == to_q);

    // next-state and next-output logic; outputs follow the next state so they are aligned with it
    always_comb begin
        state_d      = state_q;
        lvl_b_d      = lvl_b_q;
        to_d         = to_q;
        ts_t0_d      = ts_t0_q;
        ts_t1_d      = ts_t1_q;
        rst_cnt_d    = rst_cnt_q;
        trig_reset_d = 1'b0;
        add_d        = SEL_NONE;
        level_d      = level_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    state_d = S_LOAD_A;
                    lvl_b_d = cfg_level_b;
                    to_d    = cfg_timeout;
                    ts_t0_d = TS_ONES;
                    ts_t1_d = TS_ONES;
                    add_d   = SEL_A;
                    level_d = cfg_level_a;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_A: begin
                state_d = S_LOAD_B;
                add_d   = SEL_B;
                level_d = lvl_b_q;
            end
            S_LOAD_B: begin
                state_d      = S_RST;
                rst_cnt_d    = {RC_W{1'b0}};
                trig_reset_d = 1'b1;
            end
            S_RST: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d = S_ARM;
                end else begin
                    rst_cnt_d    = rst_cnt_q + 1'b1;
                    trig_reset_d = 1'b1;
                end
            end
            S_ARM: begin
                if (fall0_s && seen_high_q) begin
                    state_d = S_WAIT_T1;
                    ts_t0_d = ts_cnt_q;
                end else if (to_hit_s) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_WAIT_T1: begin
                if (rise1_s) begin
                    state_d = S_FINISH;
                    ts_t1_d = ts_cnt_q;
                    done_d  = 1'b1;
                end else if (to_hit_s) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_WAIT_T1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // abort overrides every event outside IDLE
        if (cmd_abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            trig_reset_d = 1'b1;
            add_d        = SEL_NONE;
            level_d      = level_q;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
            ts_t0_d      = ts_t0_q;
            ts_t1_d      = ts_t1_q;
        end else begin
            state_d = state_d;
        end

        if ((state_d == S_RST) && (state_q != S_RST)) begin
            ts_cnt_d = TS_ZERO;
        end else if ((state_d inside {S_RST, S_ARM, S_WAIT_T1}) && (ts_cnt_q != TS_ONES)) begin
            ts_cnt_d = ts_cnt_q + 1'b1;
        end else begin
            ts_cnt_d = ts_cnt_q;
        end

        seen_high_d = (state_q == S_ARM) ? (seen_high_q | trigger0) : 1'b0;
        busy_d      = (state_d != S_IDLE);
    end

    // state and registered outputs
    always_ff @(posedge adc_clk) begin
        if (!adc_rst_n) begin
            state_q      <= S_IDLE;
            lvl_b_q      <= 16'h0000;
            to_q         <= TS_ZERO;
            ts_cnt_q     <= TS_ZERO;
            ts_t0_q      <= TS_ONES;
            ts_t1_q      <= TS_ONES;
            rst_cnt_q    <= {RC_W{1'b0}};
            seen_high_q  <= 1'b0;
            trig_reset_q <= 1'b1;
            add_q        <= SEL_NONE;
            level_q      <= 16'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lvl_b_q      <= lvl_b_d;
            to_q         <= to_d;
            ts_cnt_q     <= ts_cnt_d;
            ts_t0_q      <= ts_t0_d;
            ts_t1_q      <= ts_t1_d;
            rst_cnt_q    <= rst_cnt_d;
            seen_high_q  <= seen_high_d;
            trig_reset_q <= trig_reset_d;
            add_q        <= add_d;
            level_q      <= level_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign trig_reset     = trig_reset_q;
    assign trig_level_add = add_q;
    assign trig_level     = level_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign ts_t0          = ts_t0_q;
    assign ts_t1          = ts_t1_q;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Directed bench for trig_seq_ctrl; expected values are hand-derived cycle counts.
module tb_trig_seq_ctrl;

    logic        adc_clk;
    logic        adc_rst_n;
    logic        cmd_start;
    logic        cmd_abort;
    logic [15:0] cfg_level_a;
    logic [15:0] cfg_level_b;
    logic [31:0] cfg_timeout;
    logic        trigger0;
    logic        trigger1;
    logic        trig_reset;
    logic [1:0]  trig_level_add;
    logic [15:0] trig_level;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] ts_t0;
    logic [31:0] ts_t1;

    int checks_cnt;
    int errors_cnt;
    logic [31:0] all_ones;

    trig_seq_ctrl #(.TS_WIDTH(32), .RST_CYCLES(4)) u_dut (
        .adc_clk(adc_clk), .adc_rst_n(adc_rst_n),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_level_a(cfg_level_a), .cfg_level_b(cfg_level_b), .cfg_timeout(cfg_timeout),
        .trigger0(trigger0), .trigger1(trigger1),
        .trig_reset(trig_reset), .trig_level_add(trig_level_add), .trig_level(trig_level),
        .busy(busy), .done(done), .timeout(timeout), .ts_t0(ts_t0), .ts_t1(ts_t1)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    // Pulses cmd_start; returns one cycle after the start edge (LOAD_A visible).
    task automatic start_seq(input logic [15:0] a, input logic [15:0] b, input logic [31:0] to);
        cfg_level_a = a;
        cfg_level_b = b;
        cfg_timeout = to;
        cmd_start   = 1'b1;
        tick();
        cmd_start   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_trig_reset"}, 64'(trig_reset), 64'd1);
        check_val({tag, "_add"}, 64'(trig_level_add), 64'd0);
        check_val({tag, "_level"}, 64'(trig_level), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_timeout"}, 64'(timeout), 64'd0);
        check_val({tag, "_ts_t0"}, 64'(ts_t0), 64'(all_ones));
        check_val({tag, "_ts_t1"}, 64'(ts_t1), 64'(all_ones));
    endtask

    initial begin
        int rst_hi;
        int done_n;
        int to_at;

        checks_cnt  = 0;
        errors_cnt  = 0;
        all_ones    = 32'hFFFF_FFFF;
        adc_rst_n   = 1'b0;
        cmd_start   = 1'b0;
        cmd_abort   = 1'b0;
        cfg_level_a = 16'h0000;
        cfg_level_b = 16'h0000;
        cfg_timeout = 32'd0;
        trigger0    = 1'b0;
        trigger1    = 1'b0;

        tick();
        tick();
        check_reset_outputs("por");
        adc_rst_n = 1'b1;
        tick();
        check_val("idle_trig_reset", 64'(trig_reset), 64'd0);

        // 1: full sequence, no timeout
        start_seq(16'h0100, 16'hFF00, 32'd0);
        check_val("s1_add_a", 64'(trig_level_add), 64'd1);
        check_val("s1_level_a", 64'(trig_level), 64'h0100);
        check_val("s1_busy", 64'(busy), 64'd1);
        tick();
        check_val("s1_add_b", 64'(trig_level_add), 64'd2);
        check_val("s1_level_b", 64'(trig_level), 64'hFF00);
        rst_hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (trig_reset) rst_hi++;
            if (i == 0) check_val("s1_add_idle", 64'(trig_level_add), 64'd0);
        end
        check_val("s1_rst_cycles", 64'(rst_hi), 64'd4);
        trigger0 = 1'b1;
        repeat (10) tick();
        trigger0 = 1'b0;
        repeat (50) tick();
        trigger1 = 1'b1;
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_n++;
        end
        trigger1 = 1'b0;
        check_val("s1_done_pulses", 64'(done_n), 64'd1);
        check_val("s1_ts_t0", 64'(ts_t0), 64'd16);
        check_val("s1_ts_t1", 64'(ts_t1), 64'd66);
        check_val("s1_ts_diff", 64'(ts_t1 - ts_t0), 64'd50);
        check_val("s1_busy_end", 64'(busy), 64'd0);

        // 2: timeout of 100, no trigger activity
        start_seq(16'h0001, 16'h0002, 32'd100);
        to_at = -1;
        for (int k = 2; k < 200; k++) begin
            tick();
            if (timeout) begin
                to_at = k;
                break;
            end
        end
        check_val("s2_timeout_cycle", 64'(to_at), 64'd104);
        check_val("s2_ts_t0", 64'(ts_t0), 64'(all_ones));
        check_val("s2_ts_t1", 64'(ts_t1), 64'(all_ones));
        check_val("s2_busy_at_pulse", 64'(busy), 64'd1);
        tick();
        check_val("s2_busy_after", 64'(busy), 64'd0);
        check_val("s2_timeout_after", 64'(timeout), 64'd0);

        // 3: abort while waiting for trigger1
        start_seq(16'h0003, 16'h0004, 32'd0);
        repeat (7) tick();
        trigger0 = 1'b1;
        repeat (2) tick();
        trigger0 = 1'b0;
        repeat (5) tick();
        check_val("s3_ts_t0", 64'(ts_t0), 64'd8);
        check_val("s3_busy_wait", 64'(busy), 64'd1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check_val("s3_busy_abort", 64'(busy), 64'd0);
        check_val("s3_trig_reset_abort", 64'(trig_reset), 64'd1);
        check_val("s3_done_abort", 64'(done), 64'd0);
        trigger1 = 1'b1;
        tick();
        check_val("s3_trig_reset_after", 64'(trig_reset), 64'd0);
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_n++;
        end
        trigger1 = 1'b0;
        check_val("s3_no_done", 64'(done_n), 64'd0);
        check_val("s3_ts_t1", 64'(ts_t1), 64'(all_ones));

        // 4: trigger1 edge detected in the same cycle the counter reaches the timeout
        start_seq(16'h0005, 16'h0006, 32'd30);
        repeat (7) tick();
        trigger0 = 1'b1;
        repeat (2) tick();
        trigger0 = 1'b0;
        repeat (22) tick();
        trigger1 = 1'b1;
        repeat (2) tick();
        check_val("s4_done", 64'(done), 64'd1);
        check_val("s4_timeout", 64'(timeout), 64'd0);
        check_val("s4_ts_t0", 64'(ts_t0), 64'd8);
        check_val("s4_ts_t1", 64'(ts_t1), 64'd30);
        tick();
        trigger1 = 1'b0;
        check_val("s4_timeout_next", 64'(timeout), 64'd0);
        check_val("s4_busy_next", 64'(busy), 64'd0);

        // 5: second start while busy is ignored, then reset in ARM
        start_seq(16'h1234, 16'h5678, 32'd0);
        tick();
        cfg_level_a = 16'hAAAA;
        cfg_timeout = 32'd5;
        cmd_start   = 1'b1;
        tick();
        cmd_start   = 1'b0;
        check_val("s5_add_ignored", 64'(trig_level_add), 64'd0);
        check_val("s5_level_ignored", 64'(trig_level), 64'h5678);
        check_val("s5_rst_phase", 64'(trig_reset), 64'd1);
        repeat (5) tick();
        check_val("s5_arm_busy", 64'(busy), 64'd1);
        check_val("s5_arm_trig_reset", 64'(trig_reset), 64'd0);
        adc_rst_n = 1'b0;
        tick();
        check_reset_outputs("s5_rst");
        adc_rst_n = 1'b1;
        tick();
        check_val("s5_post_busy", 64'(busy), 64'd0);
        check_val("s5_post_trig_reset", 64'(trig_reset), 64'd0);

        // 6: trigger0 drops just before ARM and never rises again
        trigger0 = 1'b1;
        tick();
        start_seq(16'h0007, 16'h0008, 32'd40);
        repeat (5) tick();
        trigger0 = 1'b0;
        to_at  = -1;
        done_n = 0;
        for (int k = 7; k < 100; k++) begin
            tick();
            if (done) done_n++;
            if (timeout) begin
                to_at = k;
                break;
            end
        end
        check_val("s6_timeout_cycle", 64'(to_at), 64'd44);
        check_val("s6_no_done", 64'(done_n), 64'd0);
        check_val("s6_ts_t0", 64'(ts_t0), 64'(all_ones));
        tick();
        check_val("s6_busy_end", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
